// File: rtl/watch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
// Digit index 6 is minute1 (bits [27:24]); index 0 is msec0 (bits [3:0]).
package watch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_SET   = 3'd4
    } watch_state_e;

    localparam int DEB_MS_DEF = 20;

    localparam logic [2:0] CUR_MIN1  = 3'd6;
    localparam logic [2:0] CUR_MIN0  = 3'd5;
    localparam logic [2:0] CUR_SEC1  = 3'd4;
    localparam logic [2:0] CUR_SEC0  = 3'd3;
    localparam logic [2:0] CUR_MSEC2 = 3'd2;
    localparam logic [2:0] CUR_MSEC1 = 3'd1;
    localparam logic [2:0] CUR_MSEC0 = 3'd0;

    localparam int unsigned OFF_MIN1  = 24;
    localparam int unsigned OFF_MIN0  = 20;
    localparam int unsigned OFF_SEC1  = 16;
    localparam int unsigned OFF_SEC0  = 12;
    localparam int unsigned OFF_MSEC2 = 8;
    localparam int unsigned OFF_MSEC1 = 4;
    localparam int unsigned OFF_MSEC0 = 0;

    // Tens of minutes and tens of seconds roll over after 5, everything else after 9.
    function automatic logic [3:0] digit_limit(input logic [2:0] idx);
        return (idx == CUR_MIN1 || idx == CUR_SEC1) ? 4'd5 : 4'd9;
    endfunction

    function automatic int unsigned digit_off(input logic [2:0] idx);
        case (idx)
            CUR_MIN1:  return OFF_MIN1;
            CUR_MIN0:  return OFF_MIN0;
            CUR_SEC1:  return OFF_SEC1;
            CUR_SEC0:  return OFF_SEC0;
            CUR_MSEC2: return OFF_MSEC2;
            CUR_MSEC1: return OFF_MSEC1;
            CUR_MSEC0: return OFF_MSEC0;
            default:   return OFF_MSEC0;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, stability counter and
// a one-cycle pulse on the debounced rising edge.
module key_debounce
    import watch_pkg::*;
#(
    parameter int DEB_MS = DEB_MS_DEF
) (
    input  logic clk_1Khz,
    input  logic rst,
    input  logic key_raw,
    output logic key_p
);

    localparam int CNT_W = $clog2(DEB_MS + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_MS - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             p_q, p_d;

    // Any cycle where the synchronized input matches the debounced level restarts the window.
    always_comb begin
        sync_d = {sync_q[0], key_raw};
        cnt_d  = '0;
        lvl_d  = lvl_q;
        p_d    = 1'b0;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CNT_TC) begin
                lvl_d = sync_q[1];
                p_d   = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            p_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            p_q    <= p_d;
        end
    end

    assign key_p = p_q;

endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch control sequencer: key conditioning, run/lap/pause/set FSM,
// 7-digit BCD preset editor and lap-freeze display register.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | stopped after reset or clear, counter disabled
// ST_RUN   | counting, display follows the chain
// ST_LAP   | counting, display frozen on the hold register
// ST_PAUSE | stopped, preset retained
// ST_SET   | preset editor active, cursor selects the digit
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int DEB_MS = DEB_MS_DEF
) (
    input  logic        clk_1Khz,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_lap,
    input  logic        key_set,
    input  logic [23:0] cnt_dispbuf,
    output logic        EN,
    output logic        load,
    output logic [27:0] preset,
    output logic [23:0] dispbuf_out,
    output logic        set_mode,
    output logic [2:0]  cursor
);

    logic start_p, lap_p, set_p;
    logic ev_start, ev_lap, ev_set;

    watch_state_e state_q, state_d;
    logic [2:0]   cursor_q, cursor_d;
    logic [27:0]  preset_q, preset_d;
    logic         load_q, load_d;
    logic [23:0]  hold_q, hold_d;
    logic [23:0]  disp_q, disp_d;
    logic [3:0]   dig, dig_inc;
    int unsigned  dig_off;

    key_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .key_raw  (key_start),
        .key_p    (start_p)
    );

    key_debounce #(.DEB_MS(DEB_MS)) u_deb_lap (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .key_raw  (key_lap),
        .key_p    (lap_p)
    );

    key_debounce #(.DEB_MS(DEB_MS)) u_deb_set (
        .clk_1Khz (clk_1Khz),
        .rst      (rst),
        .key_raw  (key_set),
        .key_p    (set_p)
    );

    // Simultaneous presses collapse to a single event: set beats start beats lap.
    assign ev_set   = set_p;
    assign ev_start = start_p & ~set_p;
    assign ev_lap   = lap_p & ~set_p & ~start_p;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        preset_d = preset_q;
        load_d   = 1'b0;
        hold_d   = hold_q;
        dig_off  = digit_off(cursor_q);
        dig      = preset_q[dig_off +: 4];
        dig_inc  = (dig >= digit_limit(cursor_q)) ? 4'd0 : dig + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_set) begin
                    state_d  = ST_SET;
                    cursor_d = CUR_MIN1;
                end
            end
            ST_RUN: begin
                if (ev_start) begin
                    state_d = ST_PAUSE;
                end else if (ev_lap) begin
                    hold_d  = cnt_dispbuf;
                    state_d = ST_LAP;
                end
            end
            ST_LAP: begin
                if (ev_lap) begin
                    hold_d = cnt_dispbuf;
                end else if (ev_start) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_lap) begin
                    preset_d = '0;
                    load_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (ev_set) begin
                    state_d  = ST_SET;
                    cursor_d = CUR_MIN1;
                end
            end
            ST_SET: begin
                if (ev_start) begin
                    preset_d[dig_off +: 4] = dig_inc;
                end else if (ev_lap) begin
                    cursor_d = (cursor_q == CUR_MSEC0) ? CUR_MIN1 : cursor_q - 3'd1;
                end else if (ev_set) begin
                    load_d  = 1'b1;
                    state_d = ST_PAUSE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Looking at next-state values makes a (re)capture show on the very next cycle.
        disp_d = (state_d == ST_LAP) ? hold_d : cnt_dispbuf;
    end

    always_ff @(posedge clk_1Khz or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cursor_q <= CUR_MIN1;
            preset_q <= '0;
            load_q   <= 1'b0;
            hold_q   <= '0;
            disp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            preset_q <= preset_d;
            load_q   <= load_d;
            hold_q   <= hold_d;
            disp_q   <= disp_d;
        end
    end

    assign EN          = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign set_mode    = (state_q == ST_SET);
    assign load        = load_q;
    assign preset      = preset_q;
    assign cursor      = cursor_q;
    assign dispbuf_out = disp_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl: key debounce timing, run/lap/pause flow,
// preset editing with digit wrap, clear, key priority and reset behaviour.
module tb_watch_ctrl;

    logic        clk_1Khz;
    logic        rst;
    logic        key_start, key_lap, key_set;
    logic [23:0] cnt_dispbuf;
    logic        EN, load, set_mode;
    logic [27:0] preset;
    logic [23:0] dispbuf_out;
    logic [2:0]  cursor;

    int errors = 0;
    int checks = 0;

    watch_ctrl #(.DEB_MS(20)) dut (
        .clk_1Khz    (clk_1Khz),
        .rst         (rst),
        .key_start   (key_start),
        .key_lap     (key_lap),
        .key_set     (key_set),
        .cnt_dispbuf (cnt_dispbuf),
        .EN          (EN),
        .load        (load),
        .preset      (preset),
        .dispbuf_out (dispbuf_out),
        .set_mode    (set_mode),
        .cursor      (cursor)
    );

    initial clk_1Khz = 1'b0;
    always #5 clk_1Khz = ~clk_1Khz;

    task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Press starts at a falling edge; returns #1 after the edge that acts on the press.
    task automatic press(input logic s, input logic st, input logic lp);
        @(negedge clk_1Khz);
        key_set   = s;
        key_start = st;
        key_lap   = lp;
        repeat (23) @(posedge clk_1Khz);
        #1;
    endtask

    task automatic release_keys();
        @(negedge clk_1Khz);
        key_set   = 1'b0;
        key_start = 1'b0;
        key_lap   = 1'b0;
        repeat (24) @(posedge clk_1Khz);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        key_start   = 1'b0;
        key_lap     = 1'b0;
        key_set     = 1'b0;
        cnt_dispbuf = 24'h0;
        repeat (3) @(posedge clk_1Khz);
        #1;
        check("rst_en",       28'(EN),          28'd0);
        check("rst_load",     28'(load),        28'd0);
        check("rst_preset",   preset,           28'd0);
        check("rst_disp",     28'(dispbuf_out), 28'd0);
        check("rst_set_mode", 28'(set_mode),    28'd0);
        check("rst_cursor",   28'(cursor),      28'd6);

        @(negedge clk_1Khz);
        rst = 1'b1;

        // Bounce: 3 on / 2 off for 15 cycles must not produce an event.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_1Khz);
            key_start = ((i % 5) < 3);
        end
        @(negedge clk_1Khz);
        check("bounce_no_en", 28'(EN), 28'd0);
        key_start = 1'b1;
        repeat (22) @(posedge clk_1Khz);
        #1;
        check("en_early", 28'(EN), 28'd0);
        @(posedge clk_1Khz);
        #1;
        check("en_rise", 28'(EN), 28'd1);
        repeat (17) @(posedge clk_1Khz);
        #1;
        check("en_hold_single", 28'(EN), 28'd1);
        release_keys();
        check("run_after_release", 28'(EN), 28'd1);

        // RUN: display follows live data with one cycle delay.
        @(negedge clk_1Khz);
        cnt_dispbuf = 24'h000777;
        @(posedge clk_1Khz);
        #1;
        check("run_live", 28'(dispbuf_out), 28'h0000777);

        // Lap capture and freeze.
        cnt_dispbuf = 24'h012345;
        press(1'b0, 1'b0, 1'b1);
        check("lap_capture", 28'(dispbuf_out), 28'h0012345);
        check("lap_en",      28'(EN),          28'd1);
        @(negedge clk_1Khz);
        cnt_dispbuf = 24'h999999;
        repeat (3) @(posedge clk_1Khz);
        #1;
        check("lap_freeze", 28'(dispbuf_out), 28'h0012345);
        release_keys();
        check("lap_freeze_long", 28'(dispbuf_out), 28'h0012345);

        cnt_dispbuf = 24'h054321;
        press(1'b0, 1'b0, 1'b1);
        check("lap_recapture", 28'(dispbuf_out), 28'h0054321);
        release_keys();

        // Start in LAP: pause and release the freeze.
        cnt_dispbuf = 24'h0ABCDE;
        press(1'b0, 1'b1, 1'b0);
        check("pause_en",   28'(EN),          28'd0);
        check("pause_live", 28'(dispbuf_out), 28'h00ABCDE);
        release_keys();
        @(negedge clk_1Khz);
        cnt_dispbuf = 24'h000999;
        #1;
        check("pause_delay_old", 28'(dispbuf_out), 28'h00ABCDE);
        @(posedge clk_1Khz);
        #1;
        check("pause_delay_new", 28'(dispbuf_out), 28'h0000999);

        // Clear from PAUSE to reach IDLE.
        press(1'b0, 1'b0, 1'b1);
        check("clr0_load", 28'(load), 28'd1);
        check("clr0_en",   28'(EN),   28'd0);
        @(posedge clk_1Khz);
        #1;
        check("clr0_load_one", 28'(load), 28'd0);
        release_keys();

        // Preset editing from IDLE.
        press(1'b1, 1'b0, 1'b0);
        check("set_mode_on", 28'(set_mode), 28'd1);
        check("set_cursor",  28'(cursor),   28'd6);
        check("set_en",      28'(EN),       28'd0);
        release_keys();
        for (int i = 0; i < 6; i++) begin
            press(1'b0, 1'b1, 1'b0);
            release_keys();
        end
        check("min1_wrap", preset, 28'h0000000);
        press(1'b0, 1'b1, 1'b0);
        check("min1_inc_visible", preset, 28'h1000000);
        release_keys();
        press(1'b0, 1'b0, 1'b1);
        check("cursor_dec", 28'(cursor), 28'd5);
        release_keys();
        for (int i = 0; i < 12; i++) begin
            press(1'b0, 1'b1, 1'b0);
            release_keys();
        end
        check("min0_wrap9", preset, 28'h1200000);
        press(1'b1, 1'b0, 1'b0);
        check("set_load",      28'(load),     28'd1);
        check("set_load_en",   28'(EN),       28'd0);
        check("set_load_mode", 28'(set_mode), 28'd0);
        check("set_load_pre",  preset,        28'h1200000);
        @(posedge clk_1Khz);
        #1;
        check("set_load_one", 28'(load), 28'd0);
        release_keys();

        // Clear from PAUSE, then lap in IDLE is ignored.
        press(1'b0, 1'b0, 1'b1);
        check("clr_preset", preset,     28'd0);
        check("clr_load",   28'(load),  28'd1);
        @(posedge clk_1Khz);
        #1;
        check("clr_load_one", 28'(load), 28'd0);
        release_keys();
        press(1'b0, 1'b0, 1'b1);
        check("idle_lap_en",   28'(EN),       28'd0);
        check("idle_lap_load", 28'(load),     28'd0);
        check("idle_lap_mode", 28'(set_mode), 28'd0);
        release_keys();

        // Back to PAUSE, then set+start together.
        press(1'b0, 1'b1, 1'b0);
        check("idle_start_run", 28'(EN), 28'd1);
        release_keys();
        press(1'b0, 1'b1, 1'b0);
        check("run_start_pause", 28'(EN), 28'd0);
        release_keys();
        press(1'b1, 1'b1, 1'b0);
        check("prio_set_mode", 28'(set_mode), 28'd1);
        check("prio_en",       28'(EN),       28'd0);
        check("prio_no_inc",   preset,        28'd0);
        release_keys();
        for (int i = 0; i < 6; i++) begin
            press(1'b0, 1'b0, 1'b1);
            release_keys();
        end
        check("cursor_zero", 28'(cursor), 28'd0);
        press(1'b0, 1'b0, 1'b1);
        check("cursor_wrap", 28'(cursor), 28'd6);
        release_keys();
        press(1'b0, 1'b1, 1'b0);
        check("pre_rst_preset", preset, 28'h1000000);
        release_keys();

        // Reset lands just before the edge that would raise load.
        @(negedge clk_1Khz);
        key_set = 1'b1;
        repeat (22) @(posedge clk_1Khz);
        @(negedge clk_1Khz);
        rst = 1'b0;
        #1;
        check("arst_en",     28'(EN),          28'd0);
        check("arst_mode",   28'(set_mode),    28'd0);
        check("arst_cursor", 28'(cursor),      28'd6);
        check("arst_preset", preset,           28'd0);
        check("arst_disp",   28'(dispbuf_out), 28'd0);
        @(posedge clk_1Khz);
        #1;
        check("arst_load_cancel", 28'(load), 28'd0);

        // Key held through reset: event DEB_MS+2 cycles after release of reset.
        @(negedge clk_1Khz);
        rst = 1'b1;
        repeat (22) @(posedge clk_1Khz);
        #1;
        check("held_early", 28'(set_mode), 28'd0);
        @(posedge clk_1Khz);
        #1;
        check("held_press", 28'(set_mode), 28'd1);
        release_keys();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/watch_ctrl.md
# watch_ctrl

Control sequencer for the stopwatch counter chain. Turns three raw push-buttons into the counter controls: the `EN` count enable, the one-cycle `load` strobe and the 28-bit BCD `preset` word. It also holds a 7-digit preset editor and a lap-freeze register on the 24-bit display path. It sits between the key pins and the counter chain, and between the chain's `dispbuf` and the display driver.

## Interface
Parameters:
- `DEB_MS`, default 20: debounce window, in `clk_1Khz` cycles.

Ports:
- `clk_1Khz`, in, 1: the only clock, 1 kHz.
- `rst`, in, 1: one clock; reset is asynchronous and active-low.
- `key_start`, in, 1: raw start/stop button, active-high, asynchronous. In SET it increments the selected digit.
- `key_lap`, in, 1: raw lap/clear button, active-high, asynchronous. In SET it moves the cursor.
- `key_set`, in, 1: raw preset-edit button, active-high, asynchronous.
- `cnt_dispbuf`, in, 24: live display word from the counter chain.
- `EN`, out, 1: counter enable.
- `load`, out, 1: one-cycle strobe that loads `preset` into the chain.
- `preset`, out, 28: BCD digits {minute1, minute0, sec1, sec0, msec2, msec1, msec0}, minute1 in [27:24].
- `dispbuf_out`, out, 24: word sent to the display, either live or lap-frozen.
- `set_mode`, out, 1: high while in SET.
- `cursor`, out, 3: index of the digit being edited, 6 = minute1 … 0 = msec0.

## Operation
Key conditioning:
- Each key passes through a 2-flop synchronizer, then a stability counter.
- The debounced level changes only after the synchronized input has been stable for `DEB_MS` consecutive cycles.
- A press event (`*_p`) is a one-cycle pulse on the debounced rising edge. Releases generate nothing.
- If several presses land in the same cycle, only one is acted on, by priority set > start > lap. The others are dropped.

FSM states: IDLE, RUN, LAP, PAUSE, SET.
- IDLE (reset state): `EN`=0.
  - start_p → RUN.
  - set_p → SET with `cursor`=6.
  - lap_p is ignored.
- RUN: `EN`=1.
  - start_p → PAUSE.
  - lap_p → capture `cnt_dispbuf` into the hold register, then → LAP.
  - set_p is ignored.
- LAP: `EN`=1 and the display is frozen on the hold register.
  - lap_p → recapture the hold register, stay in LAP.
  - start_p → PAUSE and release the freeze.
  - set_p is ignored.
- PAUSE: `EN`=0.
  - start_p → RUN.
  - lap_p (clear) → set `preset_reg`=0, pulse `load`, → IDLE.
  - set_p → SET with `cursor`=6.
- SET: `EN`=0, `set_mode`=1.
  - start_p → selected digit +1, wrapping 5→0 for digits 6 and 4 (tens of minutes and seconds), 9→0 for all others.
  - lap_p → `cursor` −1, wrapping 0→6.
  - set_p → pulse `load`, → PAUSE.

Registers and outputs:
- `preset` is driven directly from `preset_reg`. The register changes only in SET and on clear.
- `dispbuf_out` is registered:
  - in LAP it shows the hold register;
  - otherwise it is `cnt_dispbuf` delayed by one cycle.

## Timing
Reset values: state=IDLE, `EN`=0, `load`=0, `preset`=0, `dispbuf_out`=0, `set_mode`=0, `cursor`=6, debounced levels 0, all debounce counters 0.

Latencies:
- From a raw key edge to `*_p` is 2 synchronizer cycles plus `DEB_MS` stable cycles.
- The state register, `EN`, `set_mode` and `cursor` all update on the clock edge that samples `*_p`, one cycle after the pulse.
- `load` is high for exactly one cycle, the first cycle of the new state (PAUSE or IDLE).
  - `EN` is 0 in that cycle and `preset` is already stable.
  - `load` never coincides with `EN`=1.
- The lap capture uses the `cnt_dispbuf` value present in the same cycle as lap_p.
- A digit increment is visible on `preset` one cycle after start_p.

Boundary conditions:
- Bounce shorter than `DEB_MS` produces no event.
- Holding a key produces exactly one event.
- An asynchronous reset in any state immediately forces all reset values.
  - A `load` pulse in flight is cancelled.
  - Debounce restarts from 0, so a key held through reset gives a press event `DEB_MS`+2 cycles after release of reset.
- Illegal state encodings recover to IDLE.

## Structure
- `watch_pkg` holds:
  - the FSM state enum;
  - the `DEB_MS` default;
  - the digit-index constants, with `CUR_MIN1`=6 and `CUR_MSEC0`=0;
  - the per-digit wrap limit function (5 or 9);
  - the field offsets within the 28-bit preset.
- Sub-module `key_debounce` (synchronizer + counter + edge pulse) is instantiated three times.

## Test plan
- Start from reset; bounce `key_start` 3 cycles on / 2 off for 15 cycles, then hold it 40 cycles (`DEB_MS`=20) → a single start_p, `EN` rises exactly 23 cycles after the hold begins, no earlier pulse.
- In RUN press lap with `cnt_dispbuf`=24'h012345 → `dispbuf_out` stays at 24'h012345 while `cnt_dispbuf` keeps changing. Press start → PAUSE, and `dispbuf_out` follows live data one cycle later.
- From IDLE press set, then start ×7 → the minute1 digit wraps 5→0 and reads 1. Press lap, then start ×12 → the minute0 digit reads 2. Press set → exactly one `load` cycle with `preset`=28'h1200000 and `EN`=0, state PAUSE.
- In PAUSE press lap → `preset`=0, one `load` pulse, state IDLE. A further lap in IDLE → no change.
- Assert set and start in the same cycle while in PAUSE → only SET is entered and no digit increments.
- Assert `rst` low in the same cycle `load` would rise → `load` stays 0, all outputs return to their reset values.
